// File: rtl/proto_alu.sv
`default_nettype none
// ============================================================================
//  Module      : proto_alu
//  Description : 8-operation ALU with combinational result/carry/zero and a
//                clocked flag register for later conditional operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module proto_alu #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  input  logic              flag_we,
  output logic [DATA_W-1:0] out,
  output logic              carry,
  output logic              zero,
  output logic              carry_q,
  output logic              zero_q
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_NOT = 3'b101;
  localparam logic [2:0] c_OP_SHL = 3'b110;
  localparam logic [2:0] c_OP_SHR = 3'b111;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // The extra top bit holds the carry for ADD and the borrow for SUB:
  // the zero-extended difference wraps negative exactly when a < b.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    out   = '0;
    carry = 1'b0;
    case (opcode)
      c_OP_ADD: begin
        out   = w_sum[DATA_W-1:0];
        carry = w_sum[DATA_W];
      end
      c_OP_SUB: begin
        out   = w_diff[DATA_W-1:0];
        carry = w_diff[DATA_W];
      end
      c_OP_AND: out = a & b;
      c_OP_OR:  out = a | b;
      c_OP_XOR: out = a ^ b;
      c_OP_NOT: out = ~a;
      c_OP_SHL: begin
        out   = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      c_OP_SHR: begin
        out   = {1'b0, a[DATA_W-1:1]};
        carry = a[0];
      end
      default: begin
        out   = '0;
        carry = 1'b0;
      end
    endcase
  end

  assign zero = (out == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (flag_we) begin
      carry_q <= carry;
      zero_q  <= zero;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proto_alu.sv
`default_nettype none
// Testbench for proto_alu: queued expectations from a behavioural model,
// compared by an independent monitor on the falling clock edge.
module tb_proto_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       flag_we;
  logic [7:0] out;
  logic       carry;
  logic       zero;
  logic       carry_q;
  logic       zero_q;

  proto_alu #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .opcode  (opcode),
    .flag_we (flag_we),
    .out     (out),
    .carry   (carry),
    .zero    (zero),
    .carry_q (carry_q),
    .zero_q  (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] out;
    logic       c;
    logic       z;
    logic       cq;
    logic       zq;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Flag-register model and what it would capture at the next edge
  logic m_cq, m_zq;
  logic last_we, last_c, last_z;

  // Behavioural reference written from the arithmetic definitions
  task automatic model(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                       output logic [7:0] ro, output logic rc, output logic rz);
    int ia, ib, r;
    ia = int'(aa);
    ib = int'(bb);
    rc = 1'b0;
    case (op)
      3'd0: begin r = ia + ib;        rc = (r >= 256); end
      3'd1: begin r = ia - ib + 256;  rc = (ia < ib);  end
      3'd2: r = int'(aa & bb);
      3'd3: r = int'(aa | bb);
      3'd4: r = int'(aa ^ bb);
      3'd5: r = 255 - ia;
      3'd6: begin r = ia * 2;         rc = (ia >= 128); end
      default: begin r = ia / 2;      rc = (ia % 2 == 1); end
    endcase
    ro = 8'(r % 256);
    rz = (ro == 8'h00);
  endtask

  // One stimulus cycle: account for the edge just passed, drive, queue expectation
  task automatic step(input string tag, input logic [2:0] op, input logic [7:0] aa,
                      input logic [7:0] bb, input logic we, input logic rstn,
                      input bit directed, input logic [7:0] k_out, input logic k_c,
                      input logic k_z);
    logic [7:0] mo;
    logic       mc, mz;
    exp_t       e;
    @(posedge clk);
    #1;
    if (rst_n && last_we) begin
      m_cq = last_c;
      m_zq = last_z;
    end
    model(op, aa, bb, mo, mc, mz);
    a       = aa;
    b       = bb;
    opcode  = op;
    flag_we = we;
    rst_n   = rstn;
    if (!rstn) begin
      m_cq = 1'b0;
      m_zq = 1'b0;
    end
    e.tag = tag;
    e.out = directed ? k_out : mo;
    e.c   = directed ? k_c   : mc;
    e.z   = directed ? k_z   : mz;
    e.cq  = m_cq;
    e.zq  = m_zq;
    sb.push_back(e);
    last_we = we;
    last_c  = mc;
    last_z  = mz;
  endtask

  task automatic rnd(input string tag, input logic [2:0] op, input logic [7:0] aa,
                     input logic [7:0] bb);
    step(tag, op, aa, bb, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: results are settled well before the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (out !== e.out || carry !== e.c || zero !== e.z) begin
          n_bad++;
          $display("FAIL %s result: got out=%h carry=%b zero=%b, want out=%h carry=%b zero=%b",
                   e.tag, out, carry, zero, e.out, e.c, e.z);
        end
        n_cmp++;
        if (carry_q !== e.cq || zero_q !== e.zq) begin
          n_bad++;
          $display("FAIL %s flags: got carry_q=%b zero_q=%b, want carry_q=%b zero_q=%b",
                   e.tag, carry_q, zero_q, e.cq, e.zq);
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    opcode  = 3'd0;
    flag_we = 1'b0;
    m_cq    = 1'b0;
    m_zq    = 1'b0;
    last_we = 1'b0;
    last_c  = 1'b0;
    last_z  = 1'b1;

    // Reset state, capture, hold, asynchronous clear mid-period
    step("reset",     3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    step("add_80_80", 3'd0, 8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    step("hold_add",  3'd0, 8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    step("hold_xor",  3'd4, 8'h33, 8'h66, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    step("mid_rst",   3'd4, 8'h33, 8'h66, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step("release",   3'd1, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Directed vectors
    step("sub_04_04", 3'd1, 8'h04, 8'h04, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    step("and_33_66", 3'd2, 8'h33, 8'h66, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    step("or_33_66",  3'd3, 8'h33, 8'h66, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    step("not_11",    3'd5, 8'h11, 8'h00, 1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    step("shl_88",    3'd6, 8'h88, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
    step("shr_11",    3'd7, 8'h11, 8'h00, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0);
    step("shr_01",    3'd7, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    step("add_01_02", 3'd0, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);

    // Sweeps against the model
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        rnd("sweep_add", 3'd0, 8'(1 << i), 8'(1 << j));
        rnd("sweep_sub", 3'd1, 8'(1 << i), 8'(1 << j));
      end
    for (int ia = 0; ia < 256; ia += 17)
      for (int ib = 0; ib < 256; ib += 51) begin
        rnd("sweep_and", 3'd2, 8'(ia), 8'(ib));
        rnd("sweep_or",  3'd3, 8'(ia), 8'(ib));
        rnd("sweep_xor", 3'd4, 8'(ia), 8'(ib));
      end
    for (int ia = 0; ia < 256; ia += 17) begin
      rnd("sweep_not", 3'd5, 8'(ia), 8'($urandom));
      rnd("sweep_shl", 3'd6, 8'(ia), 8'($urandom));
      rnd("sweep_shr", 3'd7, 8'(ia), 8'($urandom));
    end

    // Random traffic with occasional resets
    for (int n = 0; n < 300; n++)
      step("random", 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 29) != 0), 1'b0, 8'h00, 1'b0, 1'b0);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
